fifo_stream_reader: RTL and testbench

Read-side controller for the team's synchronous FIFO. It drains the FIFO through its `rd_en`/`data_out`/`empty` port and presents the words as a valid/ready stream, hiding the FIFO's one-cycle read latency behind a 2-entry output buffer. It never reads an empty FIFO, so FIFO `underflow` stays low. It also keeps a delivered-beat counter and a sticky error flag for system status.

---
 rtl/fifo_pkg.sv | 6 +
 rtl/fifo_reader_sva.sv | 18 +
 rtl/fifo_skid_buf.sv | 34 +++
 rtl/fifo_stream_reader.sv | 70 +++++++
 tb/tb_fifo_stream_reader.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizes for the synchronous FIFO and its stream reader.
package fifo_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} reader_state_e;
  localparam int SKID_DEPTH = 2;
  localparam int DEF_FIFO_WIDTH = 16;
endpackage

// File: rtl/fifo_reader_sva.sv
// fifo_reader_sva: safety properties of the stream reader (no empty reads, no slot overrun, stable output).
module fifo_reader_sva #(
  parameter int W = 16
) (
  input logic         clk,
  input logic         rst_n,
  input logic         fifo_rd_en,
  input logic         fifo_empty,
  input logic [1:0]   occ,
  input logic         inflight,
  input logic         m_valid,
  input logic         m_ready,
  input logic [W-1:0] m_data
);
  a_no_empty_read: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_rd_en && fifo_empty));
  a_slot_reserved: assert property (@(posedge clk) disable iff (!rst_n) ({1'b0, occ} + {2'b0, inflight}) <= 3'd2);
  a_data_stable:   assert property (@(posedge clk) disable iff (!rst_n) m_valid && !m_ready |=> $stable(m_data));
endmodule

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry output buffer that absorbs words returning from the FIFO read latency.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = DEF_FIFO_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);
  logic [W-1:0] mem [SKID_DEPTH];
  logic head, tail;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= din;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
  assign dout = mem[head];
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains the synchronous FIFO into a valid/ready stream, hiding its read latency.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      beat_count,
  output logic                  underflow_err,
  output logic                  busy
);
  reader_state_e state, state_nxt;
  logic inflight, pop;
  logic [1:0] occ;
  assign pop        = m_valid && m_ready;
  assign m_valid    = occ != 2'd0;
  assign busy       = state != IDLE;
  // A read is only issued when its returning word is guaranteed a buffer slot.
  assign fifo_rd_en = (state == RUN) && !fifo_empty && (((occ + {1'b0, inflight}) < 2'd2) || pop);
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? ((enable && !flush) ? RUN : IDLE) :
                (state == RUN)  ? ((flush || !enable) ? DRAIN : RUN) :
                                  ((!inflight && occ == 2'd0) ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      inflight      <= 1'b0;
      beat_count    <= '0;
      underflow_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= fifo_rd_en;
      beat_count    <= beat_count + CNT_W'(pop);
      underflow_err <= underflow_err | fifo_underflow;
    end
  end
  fifo_skid_buf #(.W(FIFO_WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (fifo_data_out),
    .pop   (pop),
    .dout  (m_data),
    .occ   (occ)
  );
  fifo_reader_sva #(.W(FIFO_WIDTH)) u_sva (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .occ        (occ),
    .inflight   (inflight),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
  );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed tests of the stream reader against a behavioural synchronous FIFO.
module tb_fifo_stream_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_rd_en, fifo_empty, fifo_underflow;
  logic [15:0] fifo_data_out = '0;
  logic        m_valid, underflow_err, busy;
  logic [15:0] m_data, beat_count;
  logic        uf_model = 1'b0, uf_force = 1'b0, uf_seen = 1'b0;
  logic [15:0] mem [64];
  int wr_ptr = 0, rd_ptr = 0, rd_count = 0, cyc = 0;
  logic [15:0] got [64];
  int got_n = 0, first_rd = -1, first_v = -1, first_pop = -1, last_pop = -1;
  int checks = 0, errors = 0;

  fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .flush          (flush),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .beat_count     (beat_count),
    .underflow_err  (underflow_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_underflow = uf_model | uf_force;

  // Behavioural FIFO: registered read data, underflow pulse on a read while empty.
  always @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= wr_ptr;
      rd_count <= 0;
      uf_model <= 1'b0;
      uf_seen  <= 1'b0;
    end else begin
      uf_model <= 1'b0;
      if (fifo_rd_en) begin
        if (rd_ptr != wr_ptr) begin
          fifo_data_out <= mem[rd_ptr[5:0]];
          rd_ptr        <= rd_ptr + 1;
          rd_count      <= rd_count + 1;
        end else begin
          uf_model <= 1'b1;
          uf_seen  <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      got_n <= 0; first_rd <= -1; first_v <= -1; first_pop <= -1; last_pop <= -1;
    end else begin
      if (fifo_rd_en && first_rd < 0) first_rd <= cyc;
      if (m_valid && first_v < 0) first_v <= cyc;
      if (m_valid && m_ready) begin
        got[got_n[5:0]] <= m_data;
        got_n <= got_n + 1;
        if (first_pop < 0) first_pop <= cyc;
        last_pop <= cyc;
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; m_ready = 1'b0; uf_force = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_data !== 16'h0) begin errors++; $display("FAIL reset_m_data got %h want 0000", m_data); end
    checks++; if (beat_count !== 16'h0) begin errors++; $display("FAIL reset_beat_count got %0d want 0", beat_count); end
    checks++; if (busy !== 1'b0 || underflow_err !== 1'b0) begin errors++; $display("FAIL reset_busy_err got %b%b want 00", busy, underflow_err); end
    push_word(16'h00A1); push_word(16'h00A2); push_word(16'h00A3);
    @(posedge clk); #1 enable = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h00A1 || rd_count != 2) begin errors++; $display("FAIL prereset_full got v=%b d=%h reads=%0d want v=1 d=00a1 reads=2", m_valid, m_data, rd_count); end
    rst_n = 1'b0;
    #1;
    checks++; if ({fifo_rd_en, m_valid, busy, underflow_err} !== 4'b0 || m_data !== 16'h0 || beat_count !== 16'h0) begin errors++; $display("FAIL midrun_reset got rd=%b v=%b busy=%b err=%b d=%h cnt=%0d want all 0", fifo_rd_en, m_valid, busy, underflow_err, m_data, beat_count); end
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got busy=%b rd=%b v=%b want 000", busy, fifo_rd_en, m_valid); end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    m_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 60 && got_n < 8; i++) @(posedge clk);
    @(negedge clk);
    checks++; if (got_n != 8) begin errors++; $display("FAIL stream_count got %0d want 8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== 16'(i + 1)) begin errors++; $display("FAIL stream_order[%0d] got %h want %h", i, got[i], 16'(i + 1)); end
    end
    checks++; if (first_v - first_rd != 2) begin errors++; $display("FAIL stream_latency got %0d want 2", first_v - first_rd); end
    checks++; if (last_pop - first_pop != 7) begin errors++; $display("FAIL stream_b2b got span %0d want 7", last_pop - first_pop); end
    checks++; if (beat_count !== 16'd8 || rd_count != 8) begin errors++; $display("FAIL stream_beats got cnt=%0d reads=%0d want 8/8", beat_count, rd_count); end
    #1 enable = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 5; i++) push_word(16'(i));
    enable = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (rd_count != 2 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_reads got reads=%0d rd=%b want 2/0", rd_count, fifo_rd_en); end
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h0001) begin errors++; $display("FAIL bp_hold got v=%b d=%h want 1/0001", m_valid, m_data); end
    repeat (3) @(negedge clk);
    checks++; if (m_data !== 16'h0001 || rd_count != 2) begin errors++; $display("FAIL bp_hold_later got d=%h reads=%0d want 0001/2", m_data, rd_count); end
    m_ready = 1'b1;
    for (int i = 0; i < 40 && got_n < 5; i++) @(posedge clk);
    @(negedge clk);
    checks++; if (got_n != 5 || beat_count !== 16'd5) begin errors++; $display("FAIL bp_drain got n=%0d cnt=%0d want 5/5", got_n, beat_count); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (got[i] !== 16'(i + 1)) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], 16'(i + 1)); end
    end
  endtask

  task automatic test_empty_boundary();
    do_reset();
    push_word(16'h005A);
    m_ready = 1'b1; enable = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (rd_count != 1 || uf_seen !== 1'b0) begin errors++; $display("FAIL empty_reads got reads=%0d uf=%b want 1/0", rd_count, uf_seen); end
    checks++; if (got_n != 1 || got[0] !== 16'h005A) begin errors++; $display("FAIL empty_word got n=%0d d=%h want 1/005a", got_n, got[0]); end
    checks++; if (underflow_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL empty_status got err=%b busy=%b want 0/1", underflow_err, busy); end
  endtask

  task automatic test_flush();
    do_reset();
    push_word(16'h0B01); push_word(16'h0B02); push_word(16'h0B03);
    enable = 1'b1;
    for (int i = 0; i < 20 && m_valid !== 1'b1; i++) @(negedge clk);
    checks++; if (rd_count != 2 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL flush_setup got reads=%0d rd=%b want 2/0", rd_count, fifo_rd_en); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; enable = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL flush_drain got busy=%b rd=%b want 1/0", busy, fifo_rd_en); end
    for (int i = 0; i < 20 && busy === 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (got_n != 2 || got[0] !== 16'h0B01 || got[1] !== 16'h0B02) begin errors++; $display("FAIL flush_words got n=%0d %h %h want 2 0b01 0b02", got_n, got[0], got[1]); end
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || rd_count != 2) begin errors++; $display("FAIL flush_idle got busy=%b v=%b reads=%0d want 0/0/2", busy, m_valid, rd_count); end
    enable = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || rd_count != 2) begin errors++; $display("FAIL flush_blocks_start got busy=%b reads=%0d want 0/2", busy, rd_count); end
  endtask

  task automatic test_sticky_error();
    do_reset();
    uf_force = 1'b1;
    @(posedge clk); #1 uf_force = 1'b0;
    @(negedge clk);
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL sticky_set got %b want 1", underflow_err); end
    repeat (5) @(negedge clk);
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL sticky_hold got %b want 1", underflow_err); end
    do_reset();
    @(negedge clk);
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL sticky_clear got %b want 0", underflow_err); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_sticky_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
